// File: rtl/gate_response_checker.sv
// Built-in response checker for the basic_gate block: walks the four input
// vectors, compares all seven gate outputs against the truth table and reports.
module gate_response_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int COUNT_W       = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               in_a,
    output logic               in_b,
    input  logic               not_gate_out,
    input  logic               and_gate_out,
    input  logic               nand_gate_out,
    input  logic               or_gate_out,
    input  logic               nor_gate_out,
    input  logic               xor_gate_out,
    input  logic               xnor_gate_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [6:0]         fail_mask,
    output logic [COUNT_W-1:0] err_count,
    output logic [1:0]         first_fail_vec,
    output logic               first_fail_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0]         SETTLE_INIT = 4'(SETTLE_CYCLES);
    localparam logic [COUNT_W+3:0] ERR_MAX     = {4'b0000, {COUNT_W{1'b1}}};

    state_t             state;
    logic [1:0]         idx;
    logic [3:0]         cnt;
    logic [6:0]         resp_s;
    logic [6:0]         golden_s;
    logic [6:0]         mism_s;
    logic [2:0]         mism_cnt_s;
    logic [COUNT_W+3:0] err_sum_s;
    logic [COUNT_W-1:0] err_next_s;
    logic [1:0]         next_idx_s;

    // Truth table of basic_gate, bit order {xnor,xor,nor,or,nand,and,not}.
    function automatic logic [6:0] golden_of(input logic a, input logic b);
        golden_of = {~(a ^ b), a ^ b, ~(a | b), a | b, ~(a & b), a & b, ~a};
    endfunction

    function automatic logic [2:0] popcount7(input logic [6:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 7; i++) begin
            n = n + {2'b00, v[i]};
        end
        popcount7 = n;
    endfunction

    // Per-bit mismatch of the current vector and the saturated error total.
    always_comb begin
        resp_s   = {xnor_gate_out, xor_gate_out, nor_gate_out, or_gate_out,
                    nand_gate_out, and_gate_out, not_gate_out};
        golden_s = golden_of(in_a, in_b);
        mism_s   = 7'b0000000;
        for (int i = 0; i < 7; i++) begin
            // Case inequality so an undriven or unknown output counts as a failure.
            mism_s[i] = (resp_s[i] !== golden_s[i]);
        end
        mism_cnt_s = popcount7(mism_s);
        err_sum_s  = (COUNT_W+4)'(err_count) + (COUNT_W+4)'(mism_cnt_s);
        if (err_sum_s > ERR_MAX) begin
            err_next_s = {COUNT_W{1'b1}};
        end else begin
            err_next_s = err_sum_s[COUNT_W-1:0];
        end
        next_idx_s = idx + 2'd1;
    end

    // Run sequencer; all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            idx              <= 2'd0;
            cnt              <= 4'd0;
            in_a             <= 1'b0;
            in_b             <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail_mask        <= 7'b0000000;
            err_count        <= {COUNT_W{1'b0}};
            first_fail_vec   <= 2'd0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state            <= SETTLE;
                        idx              <= 2'd0;
                        in_a             <= 1'b0;
                        in_b             <= 1'b0;
                        cnt              <= SETTLE_INIT;
                        busy             <= 1'b1;
                        pass             <= 1'b0;
                        fail_mask        <= 7'b0000000;
                        err_count        <= {COUNT_W{1'b0}};
                        first_fail_vec   <= 2'd0;
                        first_fail_valid <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (cnt == 4'd1) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    fail_mask <= fail_mask | mism_s;
                    err_count <= err_next_s;
                    if ((mism_s != 7'b0000000) && !first_fail_valid) begin
                        first_fail_vec   <= idx;
                        first_fail_valid <= 1'b1;
                    end
                    if (idx == 2'd3) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= ((fail_mask | mism_s) == 7'b0000000);
                    end else begin
                        // Vector order 00,10,01,11 as {a,b}: a follows idx bit 0.
                        idx   <= next_idx_s;
                        in_a  <= next_idx_s[0];
                        in_b  <= next_idx_s[1];
                        cnt   <= SETTLE_INIT;
                        state <= SETTLE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench: a fault-injecting gate model drives two checkers
// (default width and a 3-bit error counter); run results are predicted up front.
module tb_gate_response_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [6:0] s0, s1, inv;

    logic       a0, b0, busy0, done0, pass0, ffv0;
    logic [6:0] fm0;
    logic [4:0] err0;
    logic [1:0] ffvec0;
    logic       a3, b3, busy3, done3, pass3, ffv3;
    logic [6:0] fm3;
    logic [2:0] err3;
    logic [1:0] ffvec3;
    logic [6:0] resp0, resp3;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt0 = 0;
    int done_cnt3 = 0;

    typedef struct {
        logic       pass;
        logic [6:0] fm;
        int         err;
        logic [1:0] ffvec;
        logic       ffv;
        int         due;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Truth table from arithmetic on 0/1 values, order {xnor,xor,nor,or,nand,and,not}.
    function automatic logic [6:0] gold(input logic a, input logic b);
        int ia, ib;
        logic [6:0] g;
        ia = int'(a);
        ib = int'(b);
        g[0] = (1 - ia) == 1;
        g[1] = (ia * ib) == 1;
        g[2] = (ia * ib) == 0;
        g[3] = (ia + ib) > 0;
        g[4] = (ia + ib) == 0;
        g[5] = (ia + ib) == 1;
        g[6] = (ia + ib) != 1;
        return g;
    endfunction

    assign resp0 = ((gold(a0, b0) ^ inv) & ~s0) | s1;
    assign resp3 = ((gold(a3, b3) ^ inv) & ~s0) | s1;

    gate_response_checker dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_a(a0), .in_b(b0),
        .not_gate_out(resp0[0]), .and_gate_out(resp0[1]), .nand_gate_out(resp0[2]),
        .or_gate_out(resp0[3]), .nor_gate_out(resp0[4]), .xor_gate_out(resp0[5]),
        .xnor_gate_out(resp0[6]), .busy(busy0), .done(done0), .pass(pass0),
        .fail_mask(fm0), .err_count(err0), .first_fail_vec(ffvec0),
        .first_fail_valid(ffv0)
    );

    gate_response_checker #(.SETTLE_CYCLES(2), .COUNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_a(a3), .in_b(b3),
        .not_gate_out(resp3[0]), .and_gate_out(resp3[1]), .nand_gate_out(resp3[2]),
        .or_gate_out(resp3[3]), .nor_gate_out(resp3[4]), .xor_gate_out(resp3[5]),
        .xnor_gate_out(resp3[6]), .busy(busy3), .done(done3), .pass(pass3),
        .fail_mask(fm3), .err_count(err3), .first_fail_vec(ffvec3),
        .first_fail_valid(ffv3)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Predict a whole run from the fault masks; start is sampled at the next edge.
    task automatic push_expected(input int set_cyc);
        logic [1:0] vtab [4];
        logic [6:0] g, r, m;
        exp_t e;
        int n;
        vtab = '{2'b00, 2'b10, 2'b01, 2'b11};
        e.fm = 7'd0; e.ffv = 1'b0; e.ffvec = 2'd0; n = 0;
        for (int i = 0; i < 4; i++) begin
            g = gold(vtab[i][1], vtab[i][0]);
            r = ((g ^ inv) & ~s0) | s1;
            m = r ^ g;
            e.fm = e.fm | m;
            n = n + $countones(m);
            if (m != 7'd0 && !e.ffv) begin
                e.ffv = 1'b1;
                e.ffvec = 2'(i);
            end
        end
        e.pass = (e.fm == 7'd0);
        e.due  = set_cyc + 4 * (2 + 1) + 1;
        e.err  = (n > 31) ? 31 : n;
        q0.push_back(e);
        e.err  = (n > 7) ? 7 : n;
        q3.push_back(e);
    endtask

    task automatic check_run(input string tag, input exp_t e, input logic p,
                             input logic [6:0] fm, input int err, input logic [1:0] fv,
                             input logic fvv, input logic [1:0] ab, input logic bz);
        chk({tag, " pass"}, int'(p), int'(e.pass));
        chk({tag, " fail_mask"}, int'(fm), int'(e.fm));
        chk({tag, " err_count"}, err, e.err);
        chk({tag, " first_fail_valid"}, int'(fvv), int'(e.ffv));
        chk({tag, " first_fail_vec"}, int'(fv), int'(e.ffvec));
        chk({tag, " done latency"}, cyc, e.due);
        chk({tag, " last vector"}, int'(ab), 3);
        chk({tag, " busy at done"}, int'(bz), 0);
    endtask

    // Monitor: compare every completed run against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (done0) begin
            done_cnt0++;
            if (q0.size() == 0) chk("dut0 unexpected done", 1, 0);
            else begin
                e = q0.pop_front();
                check_run("dut0", e, pass0, fm0, int'(err0), ffvec0, ffv0, {a0, b0}, busy0);
            end
        end
        if (done3) begin
            done_cnt3++;
            if (q3.size() == 0) chk("dut3 unexpected done", 1, 0);
            else begin
                e = q3.pop_front();
                check_run("dut3", e, pass3, fm3, int'(err3), ffvec3, ffv3, {a3, b3}, busy3);
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, " dut0 outputs zero"},
            int'({a0, b0, busy0, done0, pass0, fm0, err0, ffvec0, ffv0}), 0);
        chk({tag, " dut3 outputs zero"},
            int'({a3, b3, busy3, done3, pass3, fm3, err3, ffvec3, ffv3}), 0);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((q0.size() != 0 || q3.size() != 0) && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (q0.size() != 0 || q3.size() != 0) begin
            chk("run timeout, results pending", q0.size() + q3.size(), 0);
            q0.delete();
            q3.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input logic [6:0] ps0, input logic [6:0] ps1, input logic [6:0] pinv);
        s0 = ps0; s1 = ps1; inv = pinv;
        @(negedge clk);
        start = 1'b1;
        push_expected(cyc);
        @(negedge clk);
        start = 1'b0;
        wait_drain();
    endtask

    initial begin
        int c, d0, d3, r;
        logic [6:0] rs0, rs1, rinv;
        rst_n = 1'b0; start = 1'b0;
        s0 = 7'd0; s1 = 7'd0; inv = 7'd0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run(7'd0, 7'd0, 7'd0);
        run(7'b0100000, 7'd0, 7'd0);
        run(7'd0, 7'd0, 7'h7F);
        run(7'd0, 7'b0000010, 7'd0);

        for (int t = 0; t < 20; t++) begin
            rs0 = 7'd0; rs1 = 7'd0; rinv = 7'd0;
            for (int g = 0; g < 7; g++) begin
                r = $urandom_range(0, 5);
                if (r == 3) rs0[g] = 1'b1;
                else if (r == 4) rs1[g] = 1'b1;
                else if (r == 5) rinv[g] = 1'b1;
            end
            run(rs0, rs1, rinv);
        end

        // start held through the run and its DONE cycle: exactly one run.
        s0 = 7'd0; s1 = 7'b0001000; inv = 7'd0;
        d0 = done_cnt0; d3 = done_cnt3;
        @(negedge clk);
        start = 1'b1;
        push_expected(cyc);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k <= 12) chk("busy held mid-run", int'(busy0 & busy3), 1);
        end
        start = 1'b0;
        repeat (20) @(negedge clk);
        wait_drain();
        chk("dut0 single run with start held", done_cnt0 - d0, 1);
        chk("dut3 single run with start held", done_cnt3 - d3, 1);
        chk("idle after held start", int'(busy0 | busy3), 0);

        // Reset during SETTLE of vector 2 with errors already accumulated.
        s0 = 7'd0; s1 = 7'd0; inv = 7'h7F;
        @(negedge clk);
        start = 1'b1;
        c = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 7) @(negedge clk);
        chk("errors before mid-run reset", int'(err0), 14);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("mid-run reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no done after mid-run reset", int'(done0 | done3 | busy0 | busy3), 0);
        run(7'd0, 7'd0, 7'd0);
        chk("pass held after run", int'(pass0 & pass3), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
